// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RISC-V datapath: steps each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath selects.
module multicycle_ctrl #(
  parameter int ALU_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       imm_src,
  output logic             reg_write,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal_op,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    AOP_ADD   = 2'd0,
    AOP_SUB   = 2'd1,
    AOP_FUNCT = 2'd2
  } aluop_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_e state_q, state_d;
  aluop_e alu_op;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;  // MEMWB, MEMWRITE, ALUWB, BEQ and the unused codes
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    alu_op     = AOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_SW:   imm_src = 2'b01;
          OP_BEQ:  imm_src = 2'b10;
          OP_JAL:  imm_src = 2'b11;
          default: imm_src = 2'b00;
        endcase
        illegal_op = !(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = AOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = AOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = AOP_SUB;
        pc_write  = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase

    case (alu_op)
      AOP_SUB:   alu_control = 4'b0001;
      AOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? 4'b0001 : 4'b0000;
          3'b001:  alu_control = 4'b0100;
          3'b010,
          3'b011:  alu_control = 4'b0101;
          3'b100:  alu_control = 4'b0110;
          3'b101:  alu_control = funct7b5 ? 4'b1000 : 4'b0111;
          3'b110:  alu_control = 4'b0011;
          default: alu_control = 4'b0010;
        endcase
      end
      default:   alu_control = 4'b0000;
    endcase

    // Reset overrides everything so no enable can fire while rst_n is low.
    if (!rst_n) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 2'b00;
      reg_write   = 1'b0;
      illegal_op  = 1'b0;
      alu_control = 4'b0000;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written reset corner
// cases and a randomized run against an instruction-sequence reference model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [3:0] alu_control, state_o;

  multicycle_ctrl #(.ALU_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_write(reg_write),
    .alu_control(alu_control), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  typedef struct packed {
    logic pcw, adr, mw, irw;
    logic [1:0] rs, asa, asb, imm;
    logic rw;
    logic [3:0] alu;
    logic ill;
  } out_t;

  typedef struct packed {
    logic [2:0]  len;
    logic [23:0] s;    // state number of step i in nibble i
  } seq_t;

  out_t act;
  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, reg_write, alu_control, illegal_op};

  int n_cmp = 0, n_err = 0;
  int idx = 0;
  bit mvalid = 0;
  out_t obs;
  logic [3:0] obs_st;

  // Which states an instruction walks through, by opcode.
  function automatic seq_t seq_for(logic [6:0] o);
    case (o)
      LW:      return '{3'd5, 24'h043210};
      SW:      return '{3'd4, 24'h005210};
      RT:      return '{3'd4, 24'h008610};
      IT:      return '{3'd4, 24'h008710};
      BQ:      return '{3'd3, 24'h000910};
      JL:      return '{3'd4, 24'h008A10};
      default: return '{3'd2, 24'h000010};
    endcase
  endfunction

  function automatic logic [3:0] alu_funct(logic [6:0] o, logic [2:0] f3, logic f7);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd3, 4'd2};
    if (f3 == 3'd0 && o[5] && f7) return 4'd1;
    if (f3 == 3'd5 && f7) return 4'd8;
    return tbl[f3];
  endfunction

  function automatic out_t exp_out(logic r, logic [3:0] st, logic [6:0] o,
                                   logic [2:0] f3, logic f7, logic z);
    out_t e = '0;
    if (!r) return e;
    case (st)
      4'd0: begin e.irw = 1; e.pcw = 1; e.asb = 2'b10; e.rs = 2'b10; end
      4'd1: begin
        e.asa = 2'b01; e.asb = 2'b01;
        e.imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        e.ill = (seq_for(o).len == 3'd2);
      end
      4'd2: begin e.asa = 2'b10; e.asb = 2'b01; end
      4'd3: e.adr = 1;
      4'd4: begin e.rs = 2'b01; e.rw = 1; end
      4'd5: begin e.adr = 1; e.mw = 1; end
      4'd6: begin e.asa = 2'b10; e.alu = alu_funct(o, f3, f7); end
      4'd7: begin e.asa = 2'b10; e.asb = 2'b01; e.alu = alu_funct(o, f3, f7); end
      4'd8: e.rw = 1;
      4'd9: begin e.asa = 2'b10; e.alu = 4'd1; e.pcw = z; end
      4'd10: begin e.asa = 2'b01; e.asb = 2'b10; e.pcw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance.
  task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
    logic [3:0] est;
    rst_n = r; op = o; funct3 = f3; funct7b5 = f7; zero = z;
    #3;
    est = seq_for(o).s[idx*4 +: 4];
    obs = act; obs_st = state_o;
    if (mvalid) chk("state", {28'd0, state_o}, {28'd0, est});
    chk("outputs", {14'd0, act}, {14'd0, exp_out(r, est, o, f3, f7, z)});
    @(posedge clk); #1;
    mvalid = 1;
    if (!r) idx = 0;
    else begin
      idx++;
      if (idx >= int'(seq_for(o).len)) idx = 0;
    end
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    int         ncyc;
    logic [23:0] seq;
    int         cc;
    logic [3:0] alu;
    logic       pcw, rw, mw, ill;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{"lw",      LW, 3'b010, 0, 0, 5, 24'h043210, 4, 4'd0, 0, 1, 0, 0};
    vecs[1]  = '{"sw",      SW, 3'b010, 0, 0, 4, 24'h005210, 3, 4'd0, 0, 0, 1, 0};
    vecs[2]  = '{"sub",     RT, 3'b000, 1, 0, 4, 24'h008610, 2, 4'd1, 0, 0, 0, 0};
    vecs[3]  = '{"srai",    IT, 3'b101, 1, 0, 4, 24'h008710, 2, 4'd8, 0, 0, 0, 0};
    vecs[4]  = '{"addi_f7", IT, 3'b000, 1, 0, 4, 24'h008710, 2, 4'd0, 0, 0, 0, 0};
    vecs[5]  = '{"beq_z1",  BQ, 3'b000, 0, 1, 3, 24'h000910, 2, 4'd1, 1, 0, 0, 0};
    vecs[6]  = '{"beq_z0",  BQ, 3'b000, 0, 0, 3, 24'h000910, 2, 4'd1, 0, 0, 0, 0};
    vecs[7]  = '{"jal_pc",  JL, 3'b000, 0, 0, 4, 24'h008A10, 2, 4'd0, 1, 0, 0, 0};
    vecs[8]  = '{"jal_wb",  JL, 3'b000, 0, 0, 4, 24'h008A10, 3, 4'd0, 0, 1, 0, 0};
    vecs[9]  = '{"illegal", 7'h7F, 3'b000, 0, 0, 2, 24'h000010, 1, 4'd0, 0, 0, 0, 1};
    vecs[10] = '{"or",      RT, 3'b110, 0, 0, 4, 24'h008610, 2, 4'd3, 0, 0, 0, 0};
    vecs[11] = '{"slti",    IT, 3'b010, 1, 0, 4, 24'h008710, 2, 4'd5, 0, 0, 0, 0};

    rst_n = 0; op = '0; funct3 = '0; funct7b5 = 0; zero = 0;
    @(posedge clk); #1;

    // Reset held two cycles, then the first released cycle is FETCH.
    step(0, 7'd0, 3'd0, 0, 0);
    chk("rst_irw_low", {31'd0, obs.irw}, 32'd0);
    step(0, 7'd0, 3'd0, 0, 0);
    chk("rst_pcw_low", {31'd0, obs.pcw}, 32'd0);
    step(1, LW, 3'd0, 0, 0);
    chk("rel_state", {28'd0, obs_st}, 32'd0);
    chk("rel_irw", {31'd0, obs.irw}, 32'd1);
    chk("rel_pcw", {31'd0, obs.pcw}, 32'd1);
    chk("rel_alu", {28'd0, obs.alu}, 32'd0);

    foreach (vecs[v]) begin
      step(0, vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z);
      for (int c = 0; c < vecs[v].ncyc; c++) begin
        step(1, vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z);
        chk({vecs[v].name, "_seq"}, {28'd0, obs_st}, {28'd0, vecs[v].seq[c*4 +: 4]});
        if (c == vecs[v].cc) begin
          chk({vecs[v].name, "_alu"}, {28'd0, obs.alu}, {28'd0, vecs[v].alu});
          chk({vecs[v].name, "_pcw"}, {31'd0, obs.pcw}, {31'd0, vecs[v].pcw});
          chk({vecs[v].name, "_rw"},  {31'd0, obs.rw},  {31'd0, vecs[v].rw});
          chk({vecs[v].name, "_mw"},  {31'd0, obs.mw},  {31'd0, vecs[v].mw});
          chk({vecs[v].name, "_ill"}, {31'd0, obs.ill}, {31'd0, vecs[v].ill});
        end else if (vecs[v].ill) begin
          chk({vecs[v].name, "_ill_once"}, {31'd0, obs.ill}, 32'd0);
        end
      end
      step(1, vecs[v].op, vecs[v].f3, vecs[v].f7, vecs[v].z);
      chk({vecs[v].name, "_back"}, {28'd0, obs_st}, 32'd0);
    end

    // Reset landing in MEMWRITE: store suppressed, FETCH on the next cycle.
    step(0, SW, 3'd2, 0, 0);
    repeat (3) step(1, SW, 3'd2, 0, 0);
    step(0, SW, 3'd2, 0, 0);
    chk("rstmw_state", {28'd0, obs_st}, 32'd5);
    chk("rstmw_mw", {31'd0, obs.mw}, 32'd0);
    step(1, SW, 3'd2, 0, 0);
    chk("rstmw_fetch", {28'd0, obs_st}, 32'd0);
    chk("rstmw_irw", {31'd0, obs.irw}, 32'd1);

    // Randomized instruction stream with occasional mid-instruction resets.
    begin
      logic [6:0] cur_op;
      logic [2:0] cur_f3;
      logic       cur_f7;
      logic [6:0] ops [6];
      ops = '{LW, SW, RT, IT, BQ, JL};
      cur_op = LW; cur_f3 = 0; cur_f7 = 0;
      for (int n = 0; n < 3000; n++) begin
        if (idx == 0) begin
          cur_op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : ops[$urandom_range(0, 5)];
          cur_f3 = 3'($urandom);
          cur_f7 = 1'($urandom);
        end
        step(($urandom_range(0, 39) != 0), cur_op, cur_f3, cur_f7, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
